// File: rtl/mirfak_regfile_sb.sv
// ---------------------------------------------------------------------------
// mirfak_regfile_sb
//
// Integer register file for the Mirfak decode/writeback path, with a
// per-register pending-write scoreboard and optional write-to-read bypass.
// Decode marks a destination register pending when the producing instruction
// issues. Writeback clears the mark when it writes the result. Each read port
// reports, next to its data, whether the register it reads still waits for a
// producer.
//
// Register 0 is hard-wired: it reads 0, ignores writes and is never pending.
// Array contents are not reset. Instead, a per-register valid bit masks stale
// data, so a register that has not been written since reset reads 0.
//
// Parameters:
//   XLEN     data width in bits (>= 8)
//   NREGS    register count, power of two, >= 2
//   NRPORTS  number of read ports (1..4)
//   BYPASS   1 = same-cycle write data forwarded to the read ports
//
// Ports:
//   clk_i       clock, all state updates on the rising edge
//   rst_i       asynchronous active-high reset (clears valid/pend/count)
//   raddr_i     read addresses, port k at [k*AW +: AW]
//   rdata_o     read data, port k at [k*XLEN +: XLEN]
//   rbusy_o     per-port hazard flag: the addressed register is pending
//   waddr_i     writeback address
//   wdata_i     writeback data
//   wen_i       writeback enable
//   iaddr_i     destination register of the instruction being issued
//   issue_i     mark iaddr_i pending
//   flush_i     clear every pending mark (pipeline flush)
//   pend_cnt_o  registered count of pending registers
// ---------------------------------------------------------------------------
module mirfak_regfile_sb #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int NRPORTS = 2,
  parameter int BYPASS  = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NRPORTS*AW-1:0]   raddr_i,
  output logic [NRPORTS*XLEN-1:0] rdata_o,
  output logic [NRPORTS-1:0]      rbusy_o,
  input  logic [AW-1:0]           waddr_i,
  input  logic [XLEN-1:0]         wdata_i,
  input  logic                    wen_i,
  input  logic [AW-1:0]           iaddr_i,
  input  logic                    issue_i,
  input  logic                    flush_i,
  output logic [AW:0]             pend_cnt_o
);

  // Reject configurations the addressing scheme cannot support.
  if ((NREGS < 2) || ((NREGS & (NREGS - 1)) != 0)) begin : gBadNregs
    $error("mirfak_regfile_sb: NREGS must be a power of two and >= 2");
  end
  if ((NRPORTS < 1) || (NRPORTS > 4)) begin : gBadNrports
    $error("mirfak_regfile_sb: NRPORTS must be in 1..4");
  end
  if (XLEN < 8) begin : gBadXlen
    $error("mirfak_regfile_sb: XLEN must be >= 8");
  end

  // Storage and scoreboard state.
  logic [XLEN-1:0]  mem_q [NREGS];
  logic [NREGS-1:0] valid_q;
  logic [NREGS-1:0] valid_d;
  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;
  logic [AW:0]      pendCnt_q;
  logic [AW:0]      pendCnt_d;

  // Qualified write and issue strobes. Register 0 never takes part, and a
  // flush cancels any issue arriving in the same cycle.
  logic wrHit;
  logic issHit;

  assign wrHit  = wen_i && (waddr_i != '0);
  assign issHit = issue_i && (iaddr_i != '0) && !flush_i;

  // Data array: written on every qualified writeback, never reset. Stale
  // contents after reset are hidden by valid_q.
  always_ff @(posedge clk_i) begin
    if (wrHit) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Next-state for valid and pending bits. The write clears the pending mark
  // first, then issue may set it again so that a newer producer issued in the
  // same cycle as the older producer's writeback keeps the register pending.
  // Flush wins over issue but leaves the write's data/valid update intact.
  always_comb begin
    valid_d = valid_q;
    pend_d  = pend_q;
    if (wrHit) begin
      valid_d[waddr_i] = 1'b1;
      pend_d[waddr_i]  = 1'b0;
    end
    if (flush_i) begin
      pend_d = '0;
    end else if (issHit) begin
      pend_d[iaddr_i] = 1'b1;
    end
    valid_d[0] = 1'b0;
    pend_d[0]  = 1'b0;
  end

  // Population count of the next pending vector, so the registered count
  // moves on the same edge as the pending bits it describes.
  always_comb begin
    pendCnt_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      pendCnt_d = pendCnt_d + {{AW{1'b0}}, pend_d[i]};
    end
  end

  // Scoreboard state register with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q   <= '0;
      pend_q    <= '0;
      pendCnt_q <= '0;
    end else begin
      valid_q   <= valid_d;
      pend_q    <= pend_d;
      pendCnt_q <= pendCnt_d;
    end
  end

  assign pend_cnt_o = pendCnt_q;

  // Read ports: purely combinational. Each port resolves its own address
  // against register 0, the optional same-cycle bypass and then the array.
  // Outputs are forced to 0 while reset is held so that a bypassed write
  // cannot leak through during reset.
  for (genvar k = 0; k < NRPORTS; k++) begin : gRead
    logic [AW-1:0]   rAddr;
    logic            fwdHit;
    logic [XLEN-1:0] portData;
    logic            portBusy;

    assign rAddr  = raddr_i[k*AW +: AW];
    assign fwdHit = (BYPASS != 0) && wrHit && (waddr_i == rAddr);

    // Forwarded data is never busy: the write it carries resolves the hazard
    // as far as this reader is concerned, regardless of a concurrent issue.
    always_comb begin
      portData = '0;
      portBusy = 1'b0;
      if (!rst_i && (rAddr != '0)) begin
        if (fwdHit) begin
          portData = wdata_i;
        end else begin
          portData = valid_q[rAddr] ? mem_q[rAddr] : '0;
          portBusy = pend_q[rAddr];
        end
      end
    end

    assign rdata_o[k*XLEN +: XLEN] = portData;
    assign rbusy_o[k]              = portBusy;
  end

endmodule

// File: tb/tb_mirfak_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_mirfak_regfile_sb
//
// Self-checking bench for mirfak_regfile_sb. Two instances share clock and
// reset: instance A uses the default configuration (32 x 32 bit, 2 ports,
// bypass on), instance B a varied one (16 x 64 bit, 3 ports, bypass off).
// A behavioural model of each register file (plain arrays updated by the
// architectural rules) supplies expected values for directed and random
// scenarios.
// ---------------------------------------------------------------------------
module tb_mirfak_regfile_sb;

  localparam int A_XLEN  = 32;
  localparam int A_NREGS = 32;
  localparam int A_NP    = 2;
  localparam int A_AW    = 5;
  localparam int B_XLEN  = 64;
  localparam int B_NREGS = 16;
  localparam int B_NP    = 3;
  localparam int B_AW    = 4;

  logic clk = 1'b0;
  logic rst;

  logic [A_NP*A_AW-1:0]   aRaddr;
  logic [A_NP*A_XLEN-1:0] aRdata;
  logic [A_NP-1:0]        aRbusy;
  logic [A_AW-1:0]        aWaddr;
  logic [A_XLEN-1:0]      aWdata;
  logic                   aWen;
  logic [A_AW-1:0]        aIaddr;
  logic                   aIssue;
  logic                   aFlush;
  logic [A_AW:0]          aPendCnt;

  logic [B_NP*B_AW-1:0]   bRaddr;
  logic [B_NP*B_XLEN-1:0] bRdata;
  logic [B_NP-1:0]        bRbusy;
  logic [B_AW-1:0]        bWaddr;
  logic [B_XLEN-1:0]      bWdata;
  logic                   bWen;
  logic [B_AW-1:0]        bIaddr;
  logic                   bIssue;
  logic                   bFlush;
  logic [B_AW:0]          bPendCnt;

  int checks   = 0;
  int failures = 0;

  // Reference state for each instance.
  logic [A_XLEN-1:0] aMem   [A_NREGS];
  bit                aValid [A_NREGS];
  bit                aPend  [A_NREGS];
  logic [B_XLEN-1:0] bMem   [B_NREGS];
  bit                bValid [B_NREGS];
  bit                bPend  [B_NREGS];

  mirfak_regfile_sb #(
    .XLEN(A_XLEN), .NREGS(A_NREGS), .NRPORTS(A_NP), .BYPASS(1)
  ) dutA (
    .clk_i(clk), .rst_i(rst),
    .raddr_i(aRaddr), .rdata_o(aRdata), .rbusy_o(aRbusy),
    .waddr_i(aWaddr), .wdata_i(aWdata), .wen_i(aWen),
    .iaddr_i(aIaddr), .issue_i(aIssue), .flush_i(aFlush),
    .pend_cnt_o(aPendCnt)
  );

  mirfak_regfile_sb #(
    .XLEN(B_XLEN), .NREGS(B_NREGS), .NRPORTS(B_NP), .BYPASS(0)
  ) dutB (
    .clk_i(clk), .rst_i(rst),
    .raddr_i(bRaddr), .rdata_o(bRdata), .rbusy_o(bRbusy),
    .waddr_i(bWaddr), .wdata_i(bWdata), .wen_i(bWen),
    .iaddr_i(bIaddr), .issue_i(bIssue), .flush_i(bFlush),
    .pend_cnt_o(bPendCnt)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Expected read results, straight from the architectural read rules.
  function automatic logic [A_XLEN-1:0] aExpData(int a);
    if (a == 0) return '0;
    if (aWen && (int'(aWaddr) == a)) return aWdata;
    return aValid[a] ? aMem[a] : '0;
  endfunction

  function automatic logic aExpBusy(int a);
    if (a == 0) return 1'b0;
    if (aWen && (int'(aWaddr) == a)) return 1'b0;
    return aPend[a];
  endfunction

  function automatic int aExpCnt();
    int n = 0;
    foreach (aPend[i]) n += int'(aPend[i]);
    return n;
  endfunction

  function automatic logic [B_XLEN-1:0] bExpData(int a);
    if (a == 0) return '0;
    return bValid[a] ? bMem[a] : '0;
  endfunction

  function automatic logic bExpBusy(int a);
    if (a == 0) return 1'b0;
    return bPend[a];
  endfunction

  function automatic int bExpCnt();
    int n = 0;
    foreach (bPend[i]) n += int'(bPend[i]);
    return n;
  endfunction

  task automatic modelReset();
    foreach (aValid[i]) begin aValid[i] = 1'b0; aPend[i] = 1'b0; end
    foreach (bValid[i]) begin bValid[i] = 1'b0; bPend[i] = 1'b0; end
  endtask

  task automatic clearInputs();
    aRaddr = '0; aWaddr = '0; aWdata = '0; aWen = 1'b0;
    aIaddr = '0; aIssue = 1'b0; aFlush = 1'b0;
    bRaddr = '0; bWaddr = '0; bWdata = '0; bWen = 1'b0;
    bIaddr = '0; bIssue = 1'b0; bFlush = 1'b0;
  endtask

  // Advance one clock: apply the current inputs at the rising edge, move the
  // reference model by the same architectural step, return at the falling
  // edge ready for the next set of inputs.
  task automatic applyStimulus();
    @(posedge clk);
    if (!rst) begin
      if (aWen && (aWaddr != 0)) begin
        aMem[aWaddr] = aWdata; aValid[aWaddr] = 1'b1; aPend[aWaddr] = 1'b0;
      end
      if (aFlush) foreach (aPend[i]) aPend[i] = 1'b0;
      else if (aIssue && (aIaddr != 0)) aPend[aIaddr] = 1'b1;
      if (bWen && (bWaddr != 0)) begin
        bMem[bWaddr] = bWdata; bValid[bWaddr] = 1'b1; bPend[bWaddr] = 1'b0;
      end
      if (bFlush) foreach (bPend[i]) bPend[i] = 1'b0;
      else if (bIssue && (bIaddr != 0)) bPend[bIaddr] = 1'b1;
    end
    @(negedge clk);
  endtask

  // Reset, then every register on every port reads 0 / not busy.
  task automatic test_reset();
    clearInputs();
    rst = 1'b1;
    modelReset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (aPendCnt !== 6'd0) begin
      failures++; $display("[TB] FAIL reset_a_cnt got=%0d exp=0", aPendCnt);
    end
    checks++;
    if (bPendCnt !== 5'd0) begin
      failures++; $display("[TB] FAIL reset_b_cnt got=%0d exp=0", bPendCnt);
    end
    for (int a = 1; a < A_NREGS; a++) begin
      aRaddr = {A_NP{A_AW'(a)}};
      bRaddr = {B_NP{B_AW'(a % B_NREGS)}};
      #1;
      for (int p = 0; p < A_NP; p++) begin
        checks++;
        if ((aRdata[p*A_XLEN +: A_XLEN] !== '0) || (aRbusy[p] !== 1'b0)) begin
          failures++;
          $display("[TB] FAIL reset_a_read p%0d r%0d got=%h/%b exp=0/0",
                   p, a, aRdata[p*A_XLEN +: A_XLEN], aRbusy[p]);
        end
      end
      for (int p = 0; p < B_NP; p++) begin
        checks++;
        if ((bRdata[p*B_XLEN +: B_XLEN] !== '0) || (bRbusy[p] !== 1'b0)) begin
          failures++;
          $display("[TB] FAIL reset_b_read p%0d r%0d got=%h/%b exp=0/0",
                   p, a % B_NREGS, bRdata[p*B_XLEN +: B_XLEN], bRbusy[p]);
        end
      end
    end
    clearInputs();
  endtask

  // Basic write then read on the next cycle.
  task automatic test_write_read();
    aWen = 1'b1; aWaddr = 5'd5; aWdata = 32'hDEADBEEF;
    applyStimulus();
    clearInputs();
    aRaddr = {A_NP{5'd5}};
    #1;
    for (int p = 0; p < A_NP; p++) begin
      checks++;
      if (aRdata[p*A_XLEN +: A_XLEN] !== 32'hDEADBEEF) begin
        failures++;
        $display("[TB] FAIL write_read_r5 p%0d got=%h exp=deadbeef",
                 p, aRdata[p*A_XLEN +: A_XLEN]);
      end
    end
  endtask

  // Register 0 ignores writes and issues.
  task automatic test_r0();
    clearInputs();
    aWen = 1'b1; aWaddr = '0; aWdata = 32'h12345678;
    aIssue = 1'b1; aIaddr = '0;
    #1;
    checks++;
    if ((aRdata[0 +: A_XLEN] !== '0) || (aRbusy[0] !== 1'b0)) begin
      failures++;
      $display("[TB] FAIL r0_same_cycle got=%h/%b exp=0/0", aRdata[0 +: A_XLEN], aRbusy[0]);
    end
    applyStimulus();
    clearInputs();
    #1;
    checks++;
    if ((aRdata[A_XLEN +: A_XLEN] !== '0) || (aRbusy[1] !== 1'b0)) begin
      failures++;
      $display("[TB] FAIL r0_after got=%h/%b exp=0/0", aRdata[A_XLEN +: A_XLEN], aRbusy[1]);
    end
    checks++;
    if (aPendCnt !== 6'd0) begin
      failures++; $display("[TB] FAIL r0_cnt got=%0d exp=0", aPendCnt);
    end
  endtask

  // Issue marks pending; writeback forwards and clears.
  task automatic test_issue_bypass();
    clearInputs();
    aIssue = 1'b1; aIaddr = 5'd7;
    applyStimulus();
    clearInputs();
    aRaddr = {A_NP{5'd7}};
    #1;
    checks++;
    if ((aRbusy[0] !== 1'b1) || (aPendCnt !== 6'd1)) begin
      failures++;
      $display("[TB] FAIL issue_r7 busy=%b cnt=%0d exp busy=1 cnt=1", aRbusy[0], aPendCnt);
    end
    aWen = 1'b1; aWaddr = 5'd7; aWdata = 32'hA5A5A5A5;
    #1;
    checks++;
    if ((aRdata[A_XLEN +: A_XLEN] !== 32'hA5A5A5A5) || (aRbusy[1] !== 1'b0)) begin
      failures++;
      $display("[TB] FAIL bypass_r7 got=%h/%b exp=a5a5a5a5/0",
               aRdata[A_XLEN +: A_XLEN], aRbusy[1]);
    end
    applyStimulus();
    clearInputs();
    aRaddr = {A_NP{5'd7}};
    #1;
    checks++;
    if ((aPendCnt !== 6'd0) || (aRdata[0 +: A_XLEN] !== 32'hA5A5A5A5) || (aRbusy[0] !== 1'b0)) begin
      failures++;
      $display("[TB] FAIL after_write_r7 cnt=%0d data=%h busy=%b exp 0/a5a5a5a5/0",
               aPendCnt, aRdata[0 +: A_XLEN], aRbusy[0]);
    end
  endtask

  // Same-cycle issue and write; no-bypass read during write.
  task automatic test_issue_write_same();
    clearInputs();
    aIssue = 1'b1; aIaddr = 5'd9; aWen = 1'b1; aWaddr = 5'd9; aWdata = 32'h11;
    bWen = 1'b1; bWaddr = 4'd9; bWdata = 64'h0000_1111_0000_1111;
    applyStimulus();
    clearInputs();
    aRaddr = {A_NP{5'd9}};
    #1;
    checks++;
    if ((aRdata[0 +: A_XLEN] !== 32'h11) || (aRbusy[0] !== 1'b1) || (aPendCnt !== 6'd1)) begin
      failures++;
      $display("[TB] FAIL issue_write_r9 data=%h busy=%b cnt=%0d exp 11/1/1",
               aRdata[0 +: A_XLEN], aRbusy[0], aPendCnt);
    end
    bWen = 1'b1; bWaddr = 4'd9; bWdata = 64'h2222_2222_2222_2222;
    bRaddr = {B_NP{4'd9}};
    #1;
    for (int p = 0; p < B_NP; p++) begin
      checks++;
      if (bRdata[p*B_XLEN +: B_XLEN] !== 64'h0000_1111_0000_1111) begin
        failures++;
        $display("[TB] FAIL nobypass_old p%0d got=%h exp=0000111100001111",
                 p, bRdata[p*B_XLEN +: B_XLEN]);
      end
    end
    applyStimulus();
    clearInputs();
    bRaddr = {B_NP{4'd9}};
    #1;
    checks++;
    if (bRdata[2*B_XLEN +: B_XLEN] !== 64'h2222_2222_2222_2222) begin
      failures++;
      $display("[TB] FAIL nobypass_new got=%h exp=2222222222222222", bRdata[2*B_XLEN +: B_XLEN]);
    end
  endtask

  // Flush clears all pending marks and beats a concurrent issue.
  task automatic test_flush();
    clearInputs();
    aFlush = 1'b1;
    applyStimulus();
    clearInputs();
    #1;
    checks++;
    if (aPendCnt !== 6'd0) begin
      failures++; $display("[TB] FAIL flush_pre_cnt got=%0d exp=0", aPendCnt);
    end
    for (int r = 1; r <= 3; r++) begin
      aIssue = 1'b1; aIaddr = A_AW'(r);
      applyStimulus();
    end
    clearInputs();
    #1;
    checks++;
    if (aPendCnt !== 6'd3) begin
      failures++; $display("[TB] FAIL flush_three_cnt got=%0d exp=3", aPendCnt);
    end
    aFlush = 1'b1; aIssue = 1'b1; aIaddr = 5'd4;
    applyStimulus();
    clearInputs();
    #1;
    checks++;
    if (aPendCnt !== 6'd0) begin
      failures++; $display("[TB] FAIL flush_cnt got=%0d exp=0", aPendCnt);
    end
    for (int r = 1; r <= 4; r++) begin
      aRaddr = {A_NP{A_AW'(r)}};
      #1;
      checks++;
      if (aRbusy !== 2'b00) begin
        failures++; $display("[TB] FAIL flush_busy r%0d got=%b exp=00", r, aRbusy);
      end
    end
  endtask

  // Asynchronous reset in the middle of a cycle clears state at once.
  task automatic test_async_reset();
    clearInputs();
    aWen = 1'b1; aWaddr = 5'd3; aWdata = 32'h55; aIssue = 1'b1; aIaddr = 5'd6;
    bWen = 1'b1; bWaddr = 4'd3; bWdata = 64'h55;
    applyStimulus();
    clearInputs();
    aRaddr = {A_NP{5'd3}};
    bRaddr = {B_NP{4'd3}};
    #1;
    checks++;
    if ((aRdata[0 +: A_XLEN] !== 32'h55) || (bRdata[0 +: B_XLEN] !== 64'h55) || (aPendCnt !== 6'd1)) begin
      failures++;
      $display("[TB] FAIL pre_reset a=%h b=%h cnt=%0d exp 55/55/1",
               aRdata[0 +: A_XLEN], bRdata[0 +: B_XLEN], aPendCnt);
    end
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checks++;
    if ((aRdata[0 +: A_XLEN] !== '0) || (bRdata[0 +: B_XLEN] !== '0) || (aPendCnt !== 6'd0)) begin
      failures++;
      $display("[TB] FAIL async_reset a=%h b=%h cnt=%0d exp 0/0/0",
               aRdata[0 +: A_XLEN], bRdata[0 +: B_XLEN], aPendCnt);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ((aRdata[A_XLEN +: A_XLEN] !== '0) || (bRdata[2*B_XLEN +: B_XLEN] !== '0)) begin
      failures++;
      $display("[TB] FAIL post_reset a=%h b=%h exp 0/0",
               aRdata[A_XLEN +: A_XLEN], bRdata[2*B_XLEN +: B_XLEN]);
    end
    aWen = 1'b1; aWaddr = 5'd3; aWdata = 32'h77;
    applyStimulus();
    clearInputs();
    aRaddr = {A_NP{5'd3}};
    #1;
    checks++;
    if (aRdata[0 +: A_XLEN] !== 32'h77) begin
      failures++; $display("[TB] FAIL first_edge_write got=%h exp=77", aRdata[0 +: A_XLEN]);
    end
  endtask

  // Random traffic on both instances against the reference model.
  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      aRaddr = A_NP*A_AW'($urandom);
      aWen   = 1'($urandom_range(0, 1));
      aWaddr = A_AW'($urandom_range(0, A_NREGS - 1));
      aWdata = $urandom;
      aIssue = 1'($urandom_range(0, 1));
      aIaddr = A_AW'($urandom_range(0, A_NREGS - 1));
      aFlush = ($urandom_range(0, 15) == 0);
      bRaddr = B_NP*B_AW'($urandom);
      bWen   = 1'($urandom_range(0, 1));
      bWaddr = B_AW'($urandom_range(0, B_NREGS - 1));
      bWdata = {$urandom, $urandom};
      bIssue = 1'($urandom_range(0, 1));
      bIaddr = B_AW'($urandom_range(0, B_NREGS - 1));
      bFlush = ($urandom_range(0, 15) == 0);
      #1;
      for (int p = 0; p < A_NP; p++) begin
        int ad;
        ad = int'(aRaddr[p*A_AW +: A_AW]);
        checks++;
        if ((aRdata[p*A_XLEN +: A_XLEN] !== aExpData(ad)) || (aRbusy[p] !== aExpBusy(ad))) begin
          failures++;
          $display("[TB] FAIL rand_a_read cyc%0d p%0d r%0d got=%h/%b exp=%h/%b", cyc, p, ad,
                   aRdata[p*A_XLEN +: A_XLEN], aRbusy[p], aExpData(ad), aExpBusy(ad));
        end
      end
      for (int p = 0; p < B_NP; p++) begin
        int bd;
        bd = int'(bRaddr[p*B_AW +: B_AW]);
        checks++;
        if ((bRdata[p*B_XLEN +: B_XLEN] !== bExpData(bd)) || (bRbusy[p] !== bExpBusy(bd))) begin
          failures++;
          $display("[TB] FAIL rand_b_read cyc%0d p%0d r%0d got=%h/%b exp=%h/%b", cyc, p, bd,
                   bRdata[p*B_XLEN +: B_XLEN], bRbusy[p], bExpData(bd), bExpBusy(bd));
        end
      end
      applyStimulus();
      checks++;
      if ((aPendCnt !== 6'(aExpCnt())) || (bPendCnt !== 5'(bExpCnt()))) begin
        failures++;
        $display("[TB] FAIL rand_cnt cyc%0d a=%0d/%0d b=%0d/%0d (got/exp)",
                 cyc, aPendCnt, aExpCnt(), bPendCnt, bExpCnt());
      end
    end
    clearInputs();
  endtask

  // Scenario sequence and summary.
  initial begin
    rst = 1'b0;
    clearInputs();
    @(negedge clk);
    test_reset();
    test_write_read();
    test_r0();
    test_issue_bypass();
    test_issue_write_same();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mirfak_regfile_sb.md
Name: mirfak_regfile_sb

Overview:
Parametrised integer register file with per-register pending-write scoreboard, write-to-read bypass and reset-clean contents. Sits in the decode/writeback path of the Mirfak core. Replaces the fixed 32x32, 2-read register file. Decode marks destinations pending at issue; writeback clears them; operand reads report hazards directly.

Parameters:
XLEN, 32, data width in bits (>=8)
NREGS, 32, register count; power of two, >=2; AW = $clog2(NREGS) derived internally
NRPORTS, 2, number of read ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = no forwarding

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  asynchronous, active-high reset
raddr_i  input  NRPORTS*AW  read addresses; port k at bits [k*AW +: AW]
rdata_o  output  NRPORTS*XLEN  read data; port k at bits [k*XLEN +: XLEN]
rbusy_o  output  NRPORTS  1 = register on port k has a pending write (hazard)
waddr_i  input  AW  write address
wdata_i  input  XLEN  write data
wen_i  input  1  write enable
iaddr_i  input  AW  destination register of the instruction being issued
issue_i  input  1  mark iaddr_i pending
flush_i  input  1  clear all pending bits (pipeline flush)
pend_cnt_o  output  AW+1  number of registers currently pending

Behaviour:
- Storage: NREGS x XLEN array plus valid[NREGS] and pend[NREGS] flop vectors. Register 0 reads 0, is never written, and is never pending.
- Reset (async, immediate): valid and pend cleared to 0. Array contents are not reset. Any register with valid=0 reads 0. Outputs during reset: rdata_o = 0, rbusy_o = 0, pend_cnt_o = 0.
- Write: on clk edge with wen_i=1 and waddr_i!=0: mem[waddr_i] <= wdata_i; valid[waddr_i] <= 1; pend[waddr_i] <= 0, unless the issue rule below sets it. Writing a non-pending register is legal.
- Issue: on clk edge with issue_i=1 and iaddr_i!=0: pend[iaddr_i] <= 1. Issue and write to the same register in one cycle: data is written and pend ends at 1 (newer producer wins).
- Flush: flush_i=1 clears all pend bits at the edge and overrides issue_i in the same cycle. A write in the flush cycle still updates data and valid.
- Read (combinational, zero latency), per port k with a = raddr_k:
  - a==0 -> rdata 0, rbusy 0.
  - BYPASS=1 and wen_i and waddr_i==a -> rdata = wdata_i, rbusy = 0.
  - otherwise rdata = valid[a] ? mem[a] : 0, rbusy = pend[a].
- Bypass does not consider issue_i. rbusy reflects the pre-edge pend state except when forwarded.
- BYPASS=0: reads return the old value during a same-cycle write. The new value is visible from the next cycle.
- pend_cnt_o: registered population count of pend, updated in the same edge as pend. Range 0..NREGS-1.
- No reset mid-operation ordering hazards: rst_i asserted at any time forces all state clear. The first edge after deassertion behaves normally.
- Parameter checks: elaboration error if NREGS is not a power of two or NRPORTS is outside 1..4.

Test Plan:
1. Reset then read r1..r31 on all ports with no writes -> rdata 0, rbusy 0, pend_cnt 0. Write r5=0xDEADBEEF -> next cycle r5 reads 0xDEADBEEF.
2. Write r0=0x12345678 with issue r0 -> r0 reads 0, rbusy 0, pend_cnt unchanged.
3. Issue r7 -> rbusy=1 and pend_cnt=1 next cycle. Write r7=0xA5A5A5A5 with BYPASS=1 -> same-cycle rdata 0xA5A5A5A5, rbusy 0. After the edge pend_cnt=0.
4. Same cycle: issue r9 and write r9=0x11 -> next cycle r9 reads 0x11, rbusy 1. Repeat with BYPASS=0 and read during the write -> old value returned.
5. Issue r1, r2, r3 (pend_cnt=3), then assert flush_i together with issue r4 -> pend_cnt=0, all rbusy 0.
6. Write r3=0x55, then assert rst_i asynchronously mid-cycle -> r3 immediately reads 0, pend_cnt 0. Run with NREGS=16, NRPORTS=3, XLEN=64 to cover parameter variation.
